// File: rtl/lcd_row_sequencer.sv
`default_nettype none
// =============================================================================
// lcd_row_sequencer : HD44780 one-row refresh sequencer with Avalon-MM buffer
// Rev 1.0
// =============================================================================
module lcd_row_sequencer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned EN_CYCLES    = 12,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLR_WAIT     = 82000,
  parameter logic [6:0]  ROW_ADDR     = 7'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REFRESH} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t      state;
  phase_t      phase;
  logic [31:0] cnt;
  logic [4:0]  idx;
  logic        with_clr;
  logic        pending;
  logic        clr_flag;
  logic [7:0]  row_buf [16];

  logic        wr_buf, wr_ctrl, req_start, req_clr;
  logic [4:0]  last_idx, ld_idx;
  logic        at_end, more, go_new, new_clr, ld_clr, ld_rs, do_load;
  logic [3:0]  char_sel;
  logic [7:0]  ld_byte;
  logic        unused_wdata;

  assign wr_buf    = chipselect & ~write_n & ~address[4];
  assign wr_ctrl   = chipselect & ~write_n & (address == 5'd16);
  assign req_start = wr_ctrl & (writedata[0] | writedata[1]);
  assign req_clr   = wr_ctrl & writedata[1];
  assign lcd_rw    = 1'b0;
  assign unused_wdata = ^writedata[31:8];

  // Sequencing decisions: which byte (if any) is loaded into SETUP next edge.
  always_comb begin
    last_idx = (state == ST_INIT) ? 5'd3 : (with_clr ? 5'd17 : 5'd16);
    at_end   = (state != ST_IDLE) && (phase == PH_WAIT) && (cnt == 32'd0);
    more     = (idx != last_idx);
    go_new   = 1'b0;
    new_clr  = clr_flag | req_clr;
    if (state == ST_IDLE) begin
      go_new  = req_start;
      new_clr = req_clr;
    end else if (at_end && !more) begin
      go_new  = pending | req_start;
    end
    do_load  = go_new || (at_end && more) ||
               ((state != ST_IDLE) && (phase == PH_LOAD));
    ld_clr   = go_new ? new_clr : with_clr;
    ld_idx   = (go_new || (phase == PH_LOAD)) ? 5'd0 : idx + 5'd1;
    char_sel = ld_idx[3:0] - (ld_clr ? 4'd2 : 4'd1);
    ld_rs    = 1'b0;
    ld_byte  = 8'h00;
    if (state == ST_INIT && !go_new) begin
      case (ld_idx[1:0])
        2'd0:    ld_byte = 8'h38;
        2'd1:    ld_byte = 8'h0C;
        2'd2:    ld_byte = 8'h06;
        default: ld_byte = 8'h01;
      endcase
    end else if (ld_clr && ld_idx == 5'd0) begin
      ld_byte = 8'h01;
    end else if (ld_idx == (ld_clr ? 5'd1 : 5'd0)) begin
      ld_byte = {1'b1, ROW_ADDR};
    end else begin
      ld_byte = row_buf[char_sel];
      ld_rs   = 1'b1;
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (!address[4])
      readdata = {24'd0, row_buf[address[3:0]]};
    else if (address == 5'd16)
      readdata = {30'd0, pending, busy};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      phase    <= PH_LOAD;
      cnt      <= 32'd0;
      idx      <= 5'd0;
      with_clr <= 1'b0;
      pending  <= 1'b0;
      clr_flag <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      busy     <= 1'b1;
      for (int i = 0; i < 16; i++) row_buf[i] <= 8'h20;
    end else begin
      if (wr_buf) row_buf[address[3:0]] <= writedata[7:0];
      // A request while busy is remembered; a refresh starting this edge consumes it.
      if (req_start && state != ST_IDLE) begin
        pending <= 1'b1;
        if (req_clr) clr_flag <= 1'b1;
      end
      if (do_load) begin
        lcd_data <= ld_byte;
        lcd_rs   <= ld_rs;
        lcd_en   <= 1'b0;
        phase    <= PH_SETUP;
        cnt      <= SETUP_CYCLES - 32'd1;
        idx      <= ld_idx;
        with_clr <= ld_clr;
        busy     <= 1'b1;
        if (go_new) begin
          state    <= ST_REFRESH;
          pending  <= 1'b0;
          clr_flag <= 1'b0;
        end
      end else if (state != ST_IDLE) begin
        case (phase)
          PH_SETUP: begin
            if (cnt != 32'd0) cnt <= cnt - 32'd1;
            else begin
              phase  <= PH_PULSE;
              lcd_en <= 1'b1;
              cnt    <= EN_CYCLES - 32'd1;
            end
          end
          PH_PULSE: begin
            if (cnt != 32'd0) cnt <= cnt - 32'd1;
            else begin
              phase  <= PH_WAIT;
              lcd_en <= 1'b0;
              cnt    <= (!lcd_rs && lcd_data == 8'h01) ? CLR_WAIT - 32'd1
                                                       : CMD_WAIT - 32'd1;
            end
          end
          PH_WAIT: begin
            if (cnt != 32'd0) cnt <= cnt - 32'd1;
            else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_row_sequencer.sv
`default_nettype none
// =============================================================================
// tb_lcd_row_sequencer : scoreboard bench for lcd_row_sequencer
// Rev 1.0
// =============================================================================
module tb_lcd_row_sequencer;

  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int CMDW  = 10;
  localparam int CLRW  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = 5'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, busy;

  lcd_row_sequencer #(
    .SETUP_CYCLES(SETUP), .EN_CYCLES(EN), .CMD_WAIT(CMDW),
    .CLR_WAIT(CLRW), .ROW_ADDR(7'h40)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [15:0] gap;   // expected cycles since previous EN rise, 0 = unchecked
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mbuf [16];
  int          prev_len = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rise_count = 0;
  int          last_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: byte stream of a panel transaction -----
  task automatic push_byte(input logic rs, input logic [7:0] d, input bit contig);
    exp_t e;
    e.rs   = rs;
    e.data = d;
    e.gap  = contig ? 16'(prev_len) : 16'd0;
    sb.push_back(e);
    prev_len = SETUP + EN + ((!rs && d == 8'h01) ? CLRW : CMDW);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 1'b0);
    push_byte(1'b0, 8'h0C, 1'b1);
    push_byte(1'b0, 8'h06, 1'b1);
    push_byte(1'b0, 8'h01, 1'b1);
  endtask

  // Steps of a refresh: [01] C0 char0..char15; chars taken from the model now.
  task automatic push_refresh(input bit clr, input int from_k, input int to_k, input bit contig);
    int last;
    last = clr ? 17 : 16;
    for (int k = from_k; k <= to_k && k <= last; k++) begin
      if (clr && k == 0)         push_byte(1'b0, 8'h01, (k == from_k) ? contig : 1'b1);
      else if (k == (clr ? 1 : 0)) push_byte(1'b0, 8'hC0, (k == from_k) ? contig : 1'b1);
      else                       push_byte(1'b1, mbuf[k - (clr ? 2 : 1)], (k == from_k) ? contig : 1'b1);
    end
  endtask

  // ---------------- monitor: pops and compares at each EN rise --------------
  logic       en_prev = 1'b0, busy_prev = 1'b0, stable = 1'b1;
  int         hi_cnt = 0, busy_run = 0, last_rise = 0;
  logic [8:0] held;
  exp_t       cur;

  always @(negedge clk) begin
    if (reset) begin
      en_prev = 1'b0; busy_prev = 1'b0; hi_cnt = 0; busy_run = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        rise_count++;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_byte: got rs=%0d data=%0h expected none", lcd_rs, lcd_data);
        end else begin
          cur = sb.pop_front();
          chk("byte", {23'd0, lcd_rw, lcd_rs, lcd_data}, {24'd0, cur.rs, cur.data});
          if (cur.gap != 16'd0) chk("byte_period", cyc - last_rise, {16'd0, cur.gap});
        end
        last_rise = cyc; hi_cnt = 1; held = {lcd_rs, lcd_data}; stable = 1'b1;
      end else if (lcd_en) begin
        hi_cnt++;
        if ({lcd_rs, lcd_data} != held) stable = 1'b0;
      end else if (en_prev) begin
        chk("en_width", hi_cnt, EN);
        chk("hold_during_en", {31'd0, stable}, 32'd1);
      end
      en_prev = lcd_en;
      if (busy) busy_run++;
      else if (busy_prev) begin last_run = busy_run; busy_run = 0; end
      busy_prev = busy;
    end
  end

  // ---------------- bus and wait helpers -------------------------------------
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    if (a < 5'd16) mbuf[a[3:0]] = d[7:0];
    @(negedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; #1;
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic wait_rises(input int n);
    int t;
    for (t = 0; t < 5000 && rise_count < n; t++) begin @(negedge clk); #1; end
    if (rise_count < n) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_rise: got %0d expected %0d", rise_count, n);
    end
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 5000 && busy; t++) begin @(negedge clk); #1; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_idle: got busy=1 expected 0");
    end
  endtask

  // ---------------- stimulus -------------------------------------------------
  logic [31:0] rd;
  int          base, t0;
  bit          clr;
  logic [31:0] ctrl;

  initial begin
    for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {20'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, busy}, 32'h1);
    bus_read(5'd16, rd); chk("rst_status", rd, 32'h1);
    bus_read(5'd7, rd);  chk("rst_buf", rd, 32'h20);

    // power-on init
    push_init();
    reset = 1'b0;
    wait_rises(1); t0 = cyc;
    wait_idle();
    chk("init_span", cyc - t0, 4 * (SETUP + EN + CMDW) + CLRW - CMDW - SETUP);

    // HELLO refresh
    bus_write(5'd0, 32'h48); bus_write(5'd1, 32'h45); bus_write(5'd2, 32'h4C);
    bus_write(5'd3, 32'h4C); bus_write(5'd4, 32'hFFFF_FF4F);
    push_refresh(1'b0, 0, 16, 1'b0);
    bus_write(5'd16, 32'h1);
    chk("start_latency", {23'd0, busy, lcd_rs, lcd_data}, {23'd0, 1'b1, 1'b0, 8'hC0});
    wait_idle();
    chk("refresh_busy", last_run, 17 * (SETUP + EN + CMDW));

    // buffer writes racing a refresh
    base = rise_count;
    push_refresh(1'b0, 0, 1, 1'b0);
    bus_write(5'd16, 32'h1);
    wait_rises(base + 2);
    bus_write(5'd15, 32'h41);
    bus_write(5'd0, 32'h5A);
    push_refresh(1'b0, 2, 16, 1'b1);
    bus_read(5'd0, rd); chk("buf0_readback", rd, 32'h5A);
    wait_idle();

    // two starts during a refresh -> exactly one extra refresh
    base = rise_count;
    push_refresh(1'b0, 0, 16, 1'b0);
    push_refresh(1'b0, 0, 16, 1'b1);
    bus_write(5'd16, 32'h1);
    wait_rises(base + 3);
    bus_write(5'd16, 32'h1);
    bus_read(5'd16, rd); chk("status_pending", rd, 32'h3);
    bus_write(5'd16, 32'h1);
    wait_rises(base + 18);
    bus_read(5'd16, rd); chk("status_pending_cleared", rd, 32'h1);
    wait_idle();
    chk("double_busy", last_run, 34 * (SETUP + EN + CMDW));
    repeat (5) @(negedge clk);
    #1;
    chk("no_third_refresh", rise_count, base + 34);

    // clear + refresh from idle
    push_refresh(1'b1, 0, 17, 1'b0);
    bus_write(5'd16, 32'h3);
    chk("clear_first", {23'd0, busy, lcd_rs, lcd_data}, {23'd0, 1'b1, 1'b0, 8'h01});
    wait_idle();
    chk("clear_busy", last_run, 17 * (SETUP + EN + CMDW) + SETUP + EN + CLRW);

    // randomized buffers and control words
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++)
        bus_write(5'(i), ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(32, 126)));
      bus_read(5'($urandom_range(0, 15)), rd);
      chk("rand_readback", rd, {24'd0, mbuf[address[3:0]]});
      clr  = bit'($urandom_range(0, 1));
      ctrl = ($urandom & ~32'h3) | (clr ? (32'h2 | 32'($urandom_range(0, 1))) : 32'h1);
      push_refresh(clr, 0, 17, 1'b0);
      bus_write(5'd16, ctrl);
      wait_idle();
      chk("rand_busy", last_run, 17 * (SETUP + EN + CMDW) + (clr ? SETUP + EN + CLRW : 0));
    end

    // reset during the EN pulse of data byte 7
    base = rise_count;
    push_refresh(1'b0, 0, 16, 1'b0);
    bus_write(5'd16, 32'h1);
    wait_rises(base + 2);
    bus_write(5'd16, 32'h2);
    wait_rises(base + 9);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_en_drop", {30'd0, lcd_en, busy}, 32'h1);
    bus_read(5'd16, rd); chk("reset_pending_lost", rd, 32'h1);
    bus_read(5'd0, rd);  chk("reset_buf", rd, 32'h20);
    sb.delete();
    for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
    push_init();
    @(negedge clk); #1;
    reset = 1'b0;
    base = rise_count;
    wait_rises(base + 1); t0 = cyc;
    wait_idle();
    chk("reinit_span", cyc - t0, 4 * (SETUP + EN + CMDW) + CLRW - CMDW - SETUP);
    chk("queue_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
